// File: rtl/viterbi_k3_decoder.sv
// viterbi_k3_decoder: hard-decision Viterbi decoder for the rate-1/2 K=3 code (G0=7, G1=5),
// 4-state ACS with register-exchange survivors and valid/ready handshakes on both sides.
// Optional: define VITERBI_ERR_CNT_EN to add the err_cnt output (corrected channel bit errors).
module viterbi_k3_decoder #(
    parameter logic [2:0] G0       = 3'o7,
    parameter logic [2:0] G1       = 3'o5,
    parameter int         TB_DEPTH = 15,
    parameter int         PM_W     = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [1:0]  in_sym,
    output logic        in_ready,
    output logic        out_valid,
    output logic        out_bit,
    input  logic        out_ready
`ifdef VITERBI_ERR_CNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);
    localparam int FC_W = $clog2(TB_DEPTH + 1);
    localparam logic [PM_W-1:0] PM_MAX = {PM_W{1'b1}};
    localparam logic [3:0][PM_W-1:0] PM_INIT = {PM_MAX, PM_MAX, PM_MAX, {PM_W{1'b0}}};

    logic [3:0][PM_W-1:0]     pm, acs, pm_norm;
    logic [3:0][TB_DEPTH-1:0] path, nxt_path;
    logic [TB_DEPTH-1:0]      surv;
    logic [PM_W-1:0]          sum0, sum1, min_new;
    logic [FC_W-1:0]          fill;
    logic [1:0]               best;
    logic                     pending, accept;

    // Hamming distance between the received symbol and the branch {b,p1,p0} = {ns, p0}.
    function automatic logic [1:0] branch_metric(input logic [1:0] ns, input logic p0, input logic [1:0] sym);
        logic [2:0] v;
        logic [1:0] e;
        v = {ns, p0};
        e = {^(v & G0), ^(v & G1)} ^ sym;
        return {1'b0, e[1]} + {1'b0, e[0]};
    endfunction

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
        logic [PM_W:0] t;
        t = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
        return t[PM_W] ? PM_MAX : t[PM_W-1:0];
    endfunction

    assign in_ready = !pending && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Add-compare-select for new state {b,p1}: predecessors are {p1,0} and {p1,1}, ties go to p0=0.
    always_comb begin
        min_new  = PM_MAX;
        acs      = '0;
        pm_norm  = '0;
        nxt_path = '0;
        sum0     = '0;
        sum1     = '0;
        surv     = '0;
        for (int s = 0; s < 4; s++) begin
            sum0        = sat_add(pm[(s % 2) * 2], branch_metric(2'(s), 1'b0, in_sym));
            sum1        = sat_add(pm[(s % 2) * 2 + 1], branch_metric(2'(s), 1'b1, in_sym));
            acs[s]      = sum1 < sum0 ? sum1 : sum0;
            surv        = sum1 < sum0 ? path[(s % 2) * 2 + 1] : path[(s % 2) * 2];
            nxt_path[s] = {surv[TB_DEPTH-2:0], s >= 2};
            min_new     = acs[s] < min_new ? acs[s] : min_new;
        end
        for (int s = 0; s < 4; s++)
            pm_norm[s] = acs[s] - min_new;
    end

    // Best survivor: minimum stored metric, lowest state index on ties.
    always_comb begin
        best = 2'd0;
        for (int s = 1; s < 4; s++)
            if (pm[s] < pm[best])
                best = 2'(s);
    end

    // Metric/survivor update on accept, then output load on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm        <= PM_INIT;
            path      <= '0;
            fill      <= '0;
            pending   <= 1'b0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else if (clr) begin
            pm        <= PM_INIT;
            path      <= '0;
            fill      <= '0;
            pending   <= 1'b0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else begin
            if (accept) begin
                pm      <= pm_norm;
                path    <= nxt_path;
                fill    <= fill == FC_W'(TB_DEPTH) ? fill : fill + 1'b1;
                pending <= 1'b1;
            end else if (pending) begin
                pending <= 1'b0;
            end
            if (pending && fill == FC_W'(TB_DEPTH)) begin
                out_valid <= 1'b1;
                out_bit   <= path[best][TB_DEPTH-1];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef VITERBI_ERR_CNT_EN
    // Stored metrics always have a minimum of 0, so the new pre-normalisation minimum is the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (clr)
            err_cnt <= '0;
        else if (accept)
            err_cnt <= (17'(err_cnt) + 17'(min_new) > 17'h0FFFF) ? 16'hFFFF : err_cnt + 16'(min_new);
    end
`endif
endmodule

// File: tb/tb_viterbi_k3_decoder.sv
// tb_viterbi_k3_decoder: scoreboard bench encoding info bits, injecting errors and checking decoded output.
module tb_viterbi_k3_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [1:0] in_sym = 2'b00;
    logic       in_ready, out_valid, out_bit;
`ifdef VITERBI_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int         n_checks = 0;
    int         n_fail = 0;
    int         acc_cnt = 0;
    int         out_cnt = 0;
    logic       exp_q[$];
    logic       exp_b;
    logic       info [64];
    logic [1:0] err [64];
    logic [1:0] enc_st = 2'b00;

    always #5 clk = ~clk;

    viterbi_k3_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .in_sym   (in_sym),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_bit  (out_bit),
        .out_ready(out_ready)
`ifdef VITERBI_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshakes are sampled on the falling edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (rst_n && !clr) begin
            if (in_valid && in_ready)
                acc_cnt++;
            if (out_valid && out_ready) begin
                check("out_latency", 32'(acc_cnt >= out_cnt + 15), 1);
                exp_b = exp_q.size() > 0 ? exp_q.pop_front() : 1'bx;
                check("out_bit", 32'(out_bit), 32'(exp_b));
                out_cnt++;
            end
        end
    end

    task automatic do_reset(input logic use_clr);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (use_clr) clr = 1'b1;
        else rst_n = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        rst_n = 1'b1;
        exp_q.delete();
        acc_cnt = 0;
        out_cnt = 0;
        enc_st = 2'b00;
    endtask

    task automatic send(input logic [1:0] sym, input logic b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_sym = sym;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("in_ready_timeout", 32'(in_ready), 1);
        else exp_q.push_back(b);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic enc_send(input logic b, input logic [1:0] e);
        logic [2:0] v;
        v = {b, enc_st};
        send({^(v & 3'o7), ^(v & 3'o5)} ^ e, b);
        enc_st = {b, enc_st[1]};
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            enc_send(info[i], err[i]);
            if (i < 15) begin
                @(posedge clk);
                @(negedge clk);
                check(i < 14 ? "no_early_out" : "first_out", 32'(out_valid), i < 14 ? 0 : 1);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic drain(input int n);
        repeat (4) @(posedge clk);
        #1;
        check("out_count", out_cnt, n - 14);
    endtask

    task automatic set_info(input int mode);
        for (int i = 0; i < 64; i++) begin
            err[i] = 2'b00;
            info[i] = mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : mode == 2 ? (i < 8 ? !i[0] : 1'b0) : 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_bit", 32'(out_bit), 0);
`ifdef VITERBI_ERR_CNT_EN
        check("rst_err_cnt", 32'(err_cnt), 0);
`endif
        rst_n = 1'b1;

        set_info(0);
        run(0, 20);
        drain(20);
`ifdef VITERBI_ERR_CNT_EN
        check("zeros_err_cnt", 32'(err_cnt), 0);
`endif

        do_reset(1'b1);
        set_info(1);
        run(0, 20);
        drain(20);

        do_reset(1'b0);
        set_info(2);
        err[3] = 2'b10;
        run(0, 25);
        drain(25);
`ifdef VITERBI_ERR_CNT_EN
        check("one_err_cnt", 32'(err_cnt), 1);
`endif

        do_reset(1'b1);
        set_info(2);
        err[3] = 2'b01;
        err[9] = 2'b10;
        run(0, 25);
        drain(25);
`ifdef VITERBI_ERR_CNT_EN
        check("two_err_cnt", 32'(err_cnt), 2);
`endif

        do_reset(1'b1);
        set_info(1);
        out_ready = 1'b0;
        run(0, 15);
        in_valid = 1'b1;
        in_sym = 2'b10;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("hold_in_ready", 32'(in_ready), 0);
            check("hold_out_valid", 32'(out_valid), 1);
            check("hold_out_bit", 32'(out_bit), 1);
        end
        check("hold_no_accept", acc_cnt, 15);
        @(posedge clk); #1;
        out_ready = 1'b1;
        run(15, 20);
        drain(20);

        for (int k = 0; k < 2; k++) begin
            do_reset(1'b1);
            set_info(3);
            run(0, 10);
            do_reset(k == 0);
            @(negedge clk);
            check("restart_out_valid", 32'(out_valid), 0);
            check("restart_in_ready", 32'(in_ready), 1);
`ifdef VITERBI_ERR_CNT_EN
            check("restart_err_cnt", 32'(err_cnt), 0);
`endif
            @(posedge clk); #1;
            set_info(3);
            run(0, 20);
            drain(20);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/viterbi_k3_decoder.md
Name: viterbi_k3_decoder

Overview:
- Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code produced by the small encoder path (G0=7, G1=5 octal).
- Consumes 2-bit coded symbols through a valid/ready handshake and emits decoded bits through a valid/ready handshake.
- Uses a 4-state add-compare-select (ACS) array with register-exchange survivor memory.
- Sits directly downstream of the encoder (or of a channel/noise injector) and upstream of the byte packer / UART path.

Parameters:
- G0, 3'o7, generator polynomial for symbol bit 1 (c0), applied to {b, p1, p0}.
- G1, 3'o5, generator polynomial for symbol bit 0 (c1), applied to {b, p1, p0}.
- TB_DEPTH, 15, survivor path length in bits and the decode latency in symbols; legal range 5..32.
- PM_W, 6, path-metric width in bits; minimum 4.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous restart; same effect as reset.
- in_valid  input  1  in_sym is valid.
- in_sym  input  2  received symbol {c0, c1}.
- in_ready  output  1  decoder accepts a symbol this cycle.
- out_valid  output  1  out_bit is valid.
- out_bit  output  1  decoded information bit.
- out_ready  input  1  downstream accepts out_bit.

Behaviour:
- Reset and clr: state-0 metric = 0, states 1..3 metric = 2^PM_W-1, all survivor paths = 0, fill counter = 0, pending flag = 0, out_valid = 0, out_bit = 0.
- clr takes priority over in_valid.
- Reset asserted mid-stream drops all state, including any pending output; no partial output is emitted.
- Trellis state s = {p1, p0} = {newest, older} input bit. Input b moves state {p1,p0} to {b,p1}.
- Expected symbol on that branch: {^({b,p1,p0}&G0), ^({b,p1,p0}&G1)}.
- Branch metric = Hamming distance between in_sym and the expected symbol (0..2).
- Accept occurs when in_valid && in_ready. On the accepting edge:
  - Each new state takes the smaller of (predecessor metric + branch metric) over its two predecessors.
  - Tie goes to the predecessor with p0=0.
  - Sums saturate at 2^PM_W-1.
  - Normalisation: the minimum of the four new metrics is subtracted from all four.
  - Each survivor path = chosen predecessor's path shifted left with b inserted at bit 0.
  - Fill counter increments, saturating at TB_DEPTH.
  - Pending flag is set.
- Edge after an accept (pending=1):
  - Pending clears.
  - If fill == TB_DEPTH: out_bit <= bit TB_DEPTH-1 of the best survivor, out_valid <= 1. Best = state with the minimum metric; lowest index wins ties.
  - Otherwise no output is produced.
- in_ready = !pending && (!out_valid || out_ready). Maximum throughput is one symbol every 2 cycles.
- out_valid holds, with out_bit stable, until out_ready is seen high. It clears on that handshake unless a new load occurs on the same edge.
- Latency: the decoded bit for symbol i is presented one edge after symbol i+TB_DEPTH-1 is accepted. The first TB_DEPTH-1 accepts produce no output.
- No tail flush: the sender appends K-1 zero tail bits plus TB_DEPTH padding symbols to drain the decoder.
- Symbols presented while in_ready=0 are ignored; no state changes.

Optional Feature:
- Macro: VITERBI_ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt, 16 bits.
  - On each accept, adds the pre-normalisation minimum new metric minus the previous minimum (0..2), i.e. the count of channel bit errors corrected along the ML path.
  - Saturates at 16'hFFFF.
  - Cleared by reset and clr.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- All-zero symbols 00 ×20 after reset -> no out_valid for the first 14 accepts; then 6 outputs, all 0; err_cnt = 0.
- All-ones info stream, encoded symbols 11, 01, then 10 repeated (20 symbols) -> first output 1 after the 15th accept; every output is 1.
- Info 10101010 plus tail 00 and 15 padding zeros, encoded, with symbol 3 corrupted 10->00 -> output 10101010 followed by zeros; err_cnt = 1.
- Same stream with two single-bit errors 6 symbols apart -> output correct; err_cnt = 2.
- Hold out_ready=0 while out_valid=1 -> out_bit stable; in_ready = 0; in_valid symbols not consumed. Release -> stream resumes with no lost or duplicated bits.
- Pulse clr, then separately rst_n=0, after 10 accepts -> out_valid = 0; next output appears only after 15 fresh accepts; decoded values match the new stream.
